muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv_unit.sv | 132 +++++++++++++
 tb/tb_muldiv_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes, FSM states,
// datapath widths and the operand magnitude helper.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ITERS = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } state_e;

    // Absolute value for signed operands; unsigned operands pass through untouched.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring
// shift-subtract for divide. Purely combinational.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   operand_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic              q_bit_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] trial;

    always_comb begin
        sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        // Partial remainder shifted left with the next dividend bit, minus the divisor.
        trial   = acc_i[2*XLEN-1:XLEN-1] - {1'b0, operand_i};
        q_bit_o = 1'b0;
        acc_o   = '0;
        if (is_div_i) begin
            q_bit_o = ~trial[XLEN];
            // Low bit is left clear; the caller merges the quotient bit in.
            acc_o   = {(q_bit_o ? trial[XLEN-1:0] : acc_i[2*XLEN-2:XLEN-1]),
                       acc_i[XLEN-2:0], 1'b0};
        end else begin
            acc_o   = {sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO registers, 34-cycle latency,
// one iteration per cycle and a final sign-fixup cycle.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero
);

    localparam logic [4:0] LastIter = 5'(ITERS - 1);

    state_e            state_q;
    logic [4:0]        iter_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   operand_q;
    logic              is_div_q;
    logic              neg_res_q;
    logic              neg_rem_q;
    logic              dbz_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              done_q;
    logic              div_by_zero_q;

    logic              is_signed;
    logic [XLEN-1:0]   rs_mag;
    logic [XLEN-1:0]   rt_mag;
    logic [2*XLEN-1:0] step_acc;
    logic              step_q_bit;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_hi;
    logic [XLEN-1:0]   fix_lo;

    muldiv_step u_step (
        .is_div_i  (is_div_q),
        .acc_i     (acc_q),
        .operand_i (operand_q),
        .acc_o     (step_acc),
        .q_bit_o   (step_q_bit)
    );

    always_comb begin
        is_signed = ~op[0];
        rs_mag    = magnitude(rs_val, is_signed);
        rt_mag    = magnitude(rt_val, is_signed);
    end

    // Sign fixup of the unsigned iteration result. On divide by zero the quotient stays
    // all-ones, and the remainder (|rs| re-signed) equals rs_val.
    always_comb begin
        prod   = neg_res_q ? (~acc_q + 64'(1)) : acc_q;
        quo    = (neg_res_q && !dbz_q) ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
        rem    = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + XLEN'(1)) : acc_q[2*XLEN-1:XLEN];
        fix_hi = is_div_q ? rem : prod[2*XLEN-1:XLEN];
        fix_lo = is_div_q ? quo : prod[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            iter_q        <= '0;
            acc_q         <= '0;
            operand_q     <= '0;
            is_div_q      <= 1'b0;
            neg_res_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_q         <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (wr_hi) hi_q <= wr_data;
                    if (wr_lo) lo_q <= wr_data;
                    if (start) begin
                        is_div_q  <= op[1];
                        neg_res_q <= is_signed & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
                        neg_rem_q <= is_signed & rs_val[XLEN-1];
                        dbz_q     <= op[1] & (rt_val == '0);
                        iter_q    <= '0;
                        acc_q     <= {{XLEN{1'b0}}, (op[1] ? rs_mag : rt_mag)};
                        operand_q <= op[1] ? rt_mag : rs_mag;
                        state_q   <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q  <= step_acc | {{(2*XLEN-1){1'b0}}, step_q_bit};
                    iter_q <= iter_q + 5'd1;
                    if (iter_q == LastIter) state_q <= StFix;
                end
                StFix: begin
                    hi_q          <= fix_hi;
                    lo_q          <= fix_lo;
                    done_q        <= 1'b1;
                    div_by_zero_q <= dbz_q;
                    state_q       <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, randomized ops against an
// arithmetic reference model, busy-time interference, HI/LO writes and mid-op reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .wr_hi       (wr_hi),
        .wr_lo       (wr_lo),
        .wr_data     (wr_data),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // MIPS-style results computed with plain integer arithmetic.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] rhi,
                                      output logic [31:0] rlo, output logic rdbz);
        longint      sa;
        longint      sb;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] up;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        rdbz = 1'b0;
        rhi  = '0;
        rlo  = '0;
        if (o[1] && b == 32'd0) begin
            rhi  = a;
            rlo  = 32'hFFFF_FFFF;
            rdbz = 1'b1;
        end else begin
            case (o)
                2'b00: begin p = sa * sb; rhi = p[63:32]; rlo = p[31:0]; end
                2'b01: begin up = {32'd0, a} * {32'd0, b}; rhi = up[63:32]; rlo = up[31:0]; end
                2'b10: begin q = sa / sb; r = sa % sb; rlo = q[31:0]; rhi = r[31:0]; end
                default: begin rlo = a / b; rhi = a % b; end
            endcase
        end
    endfunction

    // Issues one op and observes 40 cycles; cycle numbering starts at 1 after the start edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, output int done_cyc, output int done_cnt,
                          output logic [31:0] rhi, output logic [31:0] rlo,
                          output logic rdbz, output bit hold_ok);
        logic [31:0] hi0;
        logic [31:0] lo0;
        hi0 = hi; lo0 = lo;
        done_cyc = -1; done_cnt = 0; hold_ok = 1'b1;
        rhi = '0; rlo = '0; rdbz = 1'b0;
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c; rhi = hi; rlo = lo; rdbz = div_by_zero;
                end
            end else if (div_by_zero !== 1'b0) begin
                hold_ok = 1'b0;
            end
            if (c <= 33 && (hi !== hi0 || lo !== lo0)) hold_ok = 1'b0;
            if (c <= 34 && busy !== 1'b1) hold_ok = 1'b0;
            if (c >= 35 && busy !== 1'b0) hold_ok = 1'b0;
            if (inject && c == 5) begin
                start = 1'b1; op = OP_MULTU; rs_val = 32'h7; rt_val = 32'h9;
            end
            if (inject && c == 6) begin start = 1'b0; wr_lo = 1'b1; wr_data = 32'h1234; end
            if (inject && c == 7) wr_lo = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        total_cnt++; if (hi !== 32'd0) $display("FAIL reset_hi got %h want 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'd0) $display("FAIL reset_lo got %h want 0", lo); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
        else pass_cnt++;
        total_cnt++;
        if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b want 0", div_by_zero);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [6] = '{OP_MULTU, OP_MULT, OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
        logic [31:0] t_a  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100,
                                  32'h8000_0000, 32'hFFFF_FFF9};
        logic [31:0] t_b  [6] = '{32'hFFFF_FFFF, 32'h5, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] e_hi [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h64, 32'h0,
                                  32'hFFFF_FFF9};
        logic [31:0] e_lo [6] = '{32'h1, 32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                  32'h8000_0000, 32'hFFFF_FFFF};
        logic        e_dz [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int          dc, dn;
        logic [31:0] rh, rl;
        logic        rz;
        bit          ok;
        for (int i = 0; i < 6; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], 1'b0, dc, dn, rh, rl, rz, ok);
            total_cnt++; if (dc != 34) $display("FAIL dir%0d_latency got %0d want 34", i, dc);
            else pass_cnt++;
            total_cnt++; if (dn != 1) $display("FAIL dir%0d_done_count got %0d want 1", i, dn);
            else pass_cnt++;
            total_cnt++; if (rh !== e_hi[i]) $display("FAIL dir%0d_hi got %h want %h", i, rh,
                                                      e_hi[i]);
            else pass_cnt++;
            total_cnt++; if (rl !== e_lo[i]) $display("FAIL dir%0d_lo got %h want %h", i, rl,
                                                      e_lo[i]);
            else pass_cnt++;
            total_cnt++; if (rz !== e_dz[i]) $display("FAIL dir%0d_dbz got %b want %b", i, rz,
                                                      e_dz[i]);
            else pass_cnt++;
            total_cnt++; if (ok !== 1'b1) $display("FAIL dir%0d_busy_hold got %b want 1", i, ok);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b, mh, ml, rh, rl;
        logic        mz, rz;
        int          dc, dn;
        bit          ok;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if (i % 6 == 5) a = 32'h8000_0000;
            ref_model(o, a, b, mh, ml, mz);
            run_op(o, a, b, 1'b0, dc, dn, rh, rl, rz, ok);
            total_cnt++;
            if (rh !== mh || rl !== ml || rz !== mz || dc != 34 || dn != 1 || ok !== 1'b1)
                $display("FAIL rnd%0d op=%0d a=%h b=%h got hi=%h lo=%h dbz=%b cyc=%0d n=%0d ok=%b want hi=%h lo=%h dbz=%b cyc=34 n=1 ok=1",
                         i, o, a, b, rh, rl, rz, dc, dn, ok, mh, ml, mz);
            else pass_cnt++;
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] mh, ml, rh, rl;
        logic        mz, rz;
        int          dc, dn;
        bit          ok;
        ref_model(OP_MULT, 32'd12345, 32'hFFFF_FFB3, mh, ml, mz);
        run_op(OP_MULT, 32'd12345, 32'hFFFF_FFB3, 1'b1, dc, dn, rh, rl, rz, ok);
        total_cnt++; if (rh !== mh) $display("FAIL busy_hi got %h want %h", rh, mh);
        else pass_cnt++;
        total_cnt++; if (rl !== ml) $display("FAIL busy_lo got %h want %h", rl, ml);
        else pass_cnt++;
        total_cnt++; if (dn != 1) $display("FAIL busy_done_count got %0d want 1", dn);
        else pass_cnt++;
        total_cnt++; if (dc != 34) $display("FAIL busy_latency got %0d want 34", dc);
        else pass_cnt++;
        total_cnt++; if (ok !== 1'b1) $display("FAIL busy_hold got %b want 1", ok);
        else pass_cnt++;
    endtask

    task automatic test_write();
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_lo = 1'b0; wr_data = 32'h0BAD_F00D;
        total_cnt++; if (hi !== 32'hDEAD_BEEF) $display("FAIL wr_both_hi got %h want deadbeef", hi);
        else pass_cnt++;
        total_cnt++; if (lo !== 32'hDEAD_BEEF) $display("FAIL wr_both_lo got %h want deadbeef", lo);
        else pass_cnt++;
        tick();
        wr_hi = 1'b0;
        total_cnt++; if (hi !== 32'h0BAD_F00D) $display("FAIL wr_hi_only got %h want 0badf00d", hi);
        else pass_cnt++;
        total_cnt++; if (lo !== 32'hDEAD_BEEF) $display("FAIL wr_lo_kept got %h want deadbeef", lo);
        else pass_cnt++;
        // Write and start in the same idle cycle.
        start = 1'b1; op = OP_DIVU; rs_val = 32'd1000; rt_val = 32'd7;
        wr_lo = 1'b1; wr_data = 32'h0000_5A5A;
        tick();
        start = 1'b0; wr_lo = 1'b0;
        total_cnt++; if (lo !== 32'h0000_5A5A) $display("FAIL wr_start_lo got %h want 00005a5a", lo);
        else pass_cnt++;
        for (int c = 0; c < 40 && done !== 1'b1; c++) tick();
        total_cnt++; if (done !== 1'b1) $display("FAIL wr_start_done got %b want 1", done);
        else pass_cnt++;
        total_cnt++; if (lo !== 32'd142 || hi !== 32'd6)
            $display("FAIL wr_start_result got hi=%h lo=%h want hi=6 lo=8e", hi, lo);
        else pass_cnt++;
        tick(); tick();
    endtask

    task automatic test_reset_midop();
        int n_done;
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h5555_AAAA;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
        start = 1'b1; op = OP_MULT; rs_val = 32'h1234_5678; rt_val = 32'hFFFF_0001;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy);
        else pass_cnt++;
        total_cnt++; if (hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL rst_mid_hilo got hi=%h lo=%h want 0/0", hi, lo);
        else pass_cnt++;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (done !== 1'b0) n_done++;
            tick();
        end
        total_cnt++; if (n_done != 0) $display("FAIL rst_mid_no_done got %0d want 0", n_done);
        else pass_cnt++;
        wr_hi = 1'b1; wr_data = 32'hA5A5_A5A5;
        tick();
        wr_hi = 1'b0;
        total_cnt++; if (hi !== 32'hA5A5_A5A5) $display("FAIL rst_mid_wr_hi got %h want a5a5a5a5", hi);
        else pass_cnt++;
        total_cnt++; if (lo !== 32'd0) $display("FAIL rst_mid_lo got %h want 0", lo);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_write();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

endmodule
